// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Front end of the 4-bit processor. Holds the program counter, drives the
// program ROM read address every cycle and tags the word that the ROM returns
// one cycle later with a valid flag and its address for the decoder.
// Handles stall, conditional jump, halt/resume and an optional return stack.
//
// Optional feature: define FETCH_CALL_STACK_EN to build the call/return stack
// (STACK_DEPTH entries, STACK_DEPTH >= 2). Without it call_en/ret_en are
// ignored and stack_err is tied low.
//
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset, also empties the stack
//   stall        in   decoder cannot accept the current word; hold it
//   jump_en      in   current instruction is a jump
//   jump_cond    in   00 always, 01 Z=1, 10 C=1, 11 Z=0
//   jump_target  in   jump / call destination
//   flag_z       in   ALU zero flag
//   flag_c       in   ALU carry flag
//   halt_req     in   current instruction is HALT
//   resume       in   leave HALT (ignored in other states)
//   call_en      in   current instruction is CALL
//   ret_en       in   current instruction is RET
//   addr_p       out  ROM read address (combinational)
//   instr_valid  out  ROM output this cycle is a live instruction
//   instr_pc     out  address of the word currently on the ROM output
//   halted       out  sequencer is in HALT
//   stack_err    out  sticky stack overflow/underflow flag
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int RESET_PC    = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [1:0]        jump_cond,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              flag_z,
    input  logic              flag_c,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              call_en,
    input  logic              ret_en,
    output logic [ADDR_W-1:0] addr_p,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted,
    output logic              stack_err
);

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              halted_q, halted_d;
    logic [ADDR_W-1:0] fetch_addr;
    logic              advance;
    logic              cond_true;

    always_comb begin
        case (jump_cond)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = flag_z;
            2'b10:   cond_true = flag_c;
            default: cond_true = ~flag_z;
        endcase
    end

`ifdef FETCH_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              stack_err_q, stack_err_d;
    logic              push, pop;
    logic              stack_empty, stack_full;
    logic [ADDR_W-1:0] stack_top;

    assign stack_empty = (sp_q == '0);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_top   = stack_q[IDX_W'(sp_q - SP_W'(1))];
    assign stack_err   = stack_err_q;
`else
    logic unused_stack_cfg;
    assign unused_stack_cfg = ^{call_en, ret_en, 32'(STACK_DEPTH)};
    assign stack_err        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        halted_d      = halted_q;
        fetch_addr    = pc_q;
        advance       = 1'b0;
`ifdef FETCH_CALL_STACK_EN
        push          = 1'b0;
        pop           = 1'b0;
        stack_err_d   = stack_err_q;
        sp_d          = sp_q;
`endif
        case (state_q)
            ST_PRIME: begin
                // Control inputs belong to no live instruction here.
                fetch_addr    = pc_q;
                advance       = 1'b1;
                instr_valid_d = 1'b1;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                if (stall) begin
                    // Re-fetch the same word so the ROM output stays put.
                    fetch_addr = instr_pc_q;
                end else if (halt_req) begin
                    fetch_addr    = instr_pc_q;
                    instr_valid_d = 1'b0;
                    halted_d      = 1'b1;
                    state_d       = ST_HALT;
                end else begin
                    advance = 1'b1;
`ifdef FETCH_CALL_STACK_EN
                    // RET takes priority over CALL; a failed stack operation
                    // degrades to a sequential fetch.
                    if (ret_en) begin
                        if (!stack_empty) begin
                            fetch_addr = stack_top;
                            pop        = 1'b1;
                        end else begin
                            stack_err_d = 1'b1;
                        end
                    end else if (call_en) begin
                        if (!stack_full) begin
                            fetch_addr = jump_target;
                            push       = 1'b1;
                        end else begin
                            stack_err_d = 1'b1;
                        end
                    end else if (jump_en && cond_true) begin
                        fetch_addr = jump_target;
                    end
`else
                    if (jump_en && cond_true) begin
                        fetch_addr = jump_target;
                    end
`endif
                end
            end
            ST_HALT: begin
                fetch_addr = instr_pc_q;
                if (resume) begin
                    halted_d = 1'b0;
                    state_d  = ST_PRIME;
                end
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase

        if (advance) begin
            instr_pc_d = fetch_addr;
            pc_d       = fetch_addr + ADDR_W'(1);
        end
`ifdef FETCH_CALL_STACK_EN
        if (push) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop) begin
            sp_d = sp_q - SP_W'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_PRIME;
            pc_q          <= ADDR_W'(RESET_PC);
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

`ifdef FETCH_CALL_STACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q        <= '0;
            stack_err_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
        end
    end

    // Return address is the word after the CALL instruction.
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
        always_ff @(posedge clk) begin
            if (rst) begin
                stack_q[gi] <= '0;
            end else if (push && (sp_q == SP_W'(gi))) begin
                stack_q[gi] <= instr_pc_q + ADDR_W'(1);
            end
        end
    end
`endif

    assign addr_p      = fetch_addr;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed stimulus for fetch_sequencer. Each stimulus cycle pushes the
// expected (cycle, instr_pc) pair when a valid word is due; an independent
// monitor pops and compares on every cycle the DUT shows instr_valid=1.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       jump_en;
    logic [1:0] jump_cond;
    logic [3:0] jump_target;
    logic       flag_z;
    logic       flag_c;
    logic       halt_req;
    logic       resume;
    logic       call_en;
    logic       ret_en;
    logic [3:0] addr_p;
    logic       instr_valid;
    logic [3:0] instr_pc;
    logic       halted;
    logic       stack_err;

    typedef struct {
        int         cyc;
        logic [3:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    bit   mon_en = 1'b0;

    fetch_sequencer #(
        .ADDR_W      (4),
        .RESET_PC    (0),
        .STACK_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_cond   (jump_cond),
        .jump_target (jump_target),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .halt_req    (halt_req),
        .resume      (resume),
        .call_en     (call_en),
        .ret_en      (ret_en),
        .addr_p      (addr_p),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .halted      (halted),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: one line per delivered instruction word.
    always @(negedge clk) begin
        if (mon_en && instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got instr_pc %0d expected no valid word (cycle %0d)",
                         instr_pc, cyc_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("cycle %0d: instr_pc=%0d (expected %0d at cycle %0d)",
                         cyc_cnt, instr_pc, e.pc, e.cyc);
                chk("instr_pc", 32'(instr_pc), 32'(e.pc));
                chk("valid_cycle", 32'(cyc_cnt), 32'(e.cyc));
            end
        end
    end

    task automatic clear_inputs();
        rst = 0; stall = 0; jump_en = 0; jump_cond = 2'b00; jump_target = 4'd0;
        flag_z = 0; flag_c = 0; halt_req = 0; resume = 0; call_en = 0; ret_en = 0;
    endtask

    // One cycle: inputs already driven by the caller. v/pc: expected word on
    // the ROM output this cycle; a: expected fetch address this cycle.
    task automatic step(input bit v, input logic [3:0] pc, input logic [3:0] a);
        exp_t e;
        if (v) begin
            e.cyc = cyc_cnt;
            e.pc  = pc;
            exp_q.push_back(e);
        end
        #2;
        chk("addr_p", 32'(addr_p), 32'(a));
        if (!v) chk("instr_valid_low", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic jmp(input logic [1:0] c, input logic [3:0] t, input logic z, input logic cy);
        jump_en = 1; jump_cond = c; jump_target = t; flag_z = z; flag_c = cy;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        // Reset state (rst still high).
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stack_err", 32'(stack_err), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_addr_p", 32'(addr_p), 32'd0);
        mon_en = 1'b1;
        rst = 0;

        // Free run with wrap: PRIME cycle then 0,1,..15,0,1,2.
        step(1'b0, 4'd0, 4'd0);
        for (int k = 1; k <= 19; k++) step(1'b1, 4'((k - 1) % 16), 4'(k % 16));

        // Two-cycle stall at instr_pc=3; resume outside HALT has no effect.
        stall = 1; step(1'b1, 4'd3, 4'd3);
        stall = 1; step(1'b1, 4'd3, 4'd3);
        resume = 1; step(1'b1, 4'd3, 4'd4);
        step(1'b1, 4'd4, 4'd5);

        // Conditional jumps.
        jmp(2'b01, 4'd9, 1'b0, 1'b0); step(1'b1, 4'd5, 4'd6);   // Z=1 not met
        jmp(2'b01, 4'd9, 1'b1, 1'b0); step(1'b1, 4'd6, 4'd9);   // Z=1 met
        jmp(2'b11, 4'd0, 1'b1, 1'b0); step(1'b1, 4'd9, 4'd10);  // Z=0 not met
        jmp(2'b10, 4'd2, 1'b0, 1'b1); step(1'b1, 4'd10, 4'd2);  // C=1 met
        jmp(2'b00, 4'd6, 1'b0, 1'b0); step(1'b1, 4'd2, 4'd6);   // always
        jmp(2'b10, 4'd0, 1'b0, 1'b0); step(1'b1, 4'd6, 4'd7);   // C=1 not met

        // Halt at 7 (beats a simultaneous jump), resume three cycles later.
        halt_req = 1; jmp(2'b00, 4'd0, 1'b0, 1'b0); step(1'b1, 4'd7, 4'd7);
        chk("halted_set", 32'(halted), 32'd1);
        step(1'b0, 4'd0, 4'd7);
        halt_req = 1; step(1'b0, 4'd0, 4'd7);
        resume = 1; step(1'b0, 4'd0, 4'd7);
        chk("halted_clr", 32'(halted), 32'd0);
        stall = 1; jmp(2'b00, 4'd0, 1'b0, 1'b0); step(1'b0, 4'd0, 4'd8); // PRIME ignores controls
        step(1'b1, 4'd8, 4'd9);

        // Reset mid-stall at instr_pc=6.
        jmp(2'b00, 4'd11, 1'b0, 1'b0); step(1'b1, 4'd9, 4'd11);
        jmp(2'b00, 4'd6, 1'b0, 1'b0); step(1'b1, 4'd11, 4'd6);
        rst = 1; stall = 1; step(1'b1, 4'd6, 4'd6);
        chk("midrst_stack_err", 32'(stack_err), 32'd0);
        chk("midrst_instr_pc", 32'(instr_pc), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd0);
        step(1'b0, 4'd0, 4'd0);
        step(1'b1, 4'd0, 4'd1);
        step(1'b1, 4'd1, 4'd2);

`ifdef FETCH_CALL_STACK_EN
        // Call at 2 -> 10, ret at 11 -> 3.
        call_en = 1; jump_target = 4'd10; step(1'b1, 4'd2, 4'd10);
        step(1'b1, 4'd10, 4'd11);
        ret_en = 1; step(1'b1, 4'd11, 4'd3);
        // Five nested calls; the fifth is a NOP and sets stack_err.
        call_en = 1; jump_target = 4'd5;  step(1'b1, 4'd3, 4'd5);
        call_en = 1; jump_target = 4'd7;  step(1'b1, 4'd5, 4'd7);
        call_en = 1; jump_target = 4'd9;  step(1'b1, 4'd7, 4'd9);
        call_en = 1; jump_target = 4'd11; step(1'b1, 4'd9, 4'd11);
        chk("stack_err_before_ovf", 32'(stack_err), 32'd0);
        call_en = 1; jump_target = 4'd13; step(1'b1, 4'd11, 4'd12);
        chk("stack_err_ovf", 32'(stack_err), 32'd1);
        ret_en = 1; step(1'b1, 4'd12, 4'd10);
        ret_en = 1; step(1'b1, 4'd10, 4'd8);
        ret_en = 1; call_en = 1; jump_target = 4'd0; step(1'b1, 4'd8, 4'd6); // ret wins
        rst = 1; step(1'b1, 4'd6, 4'd7);
        chk("stack_err_rst", 32'(stack_err), 32'd0);
        step(1'b0, 4'd0, 4'd0);
        ret_en = 1; step(1'b1, 4'd0, 4'd1);   // underflow: sequential
        chk("stack_err_unf", 32'(stack_err), 32'd1);
        step(1'b1, 4'd1, 4'd2);
`else
        // No stack: call/ret ignored, stack_err stays low.
        call_en = 1; jump_target = 4'd10; step(1'b1, 4'd2, 4'd3);
        ret_en = 1; step(1'b1, 4'd3, 4'd4);
        call_en = 1; ret_en = 1; jump_target = 4'd12; step(1'b1, 4'd4, 4'd5);
        chk("stack_err_off", 32'(stack_err), 32'd0);
        step(1'b1, 4'd5, 4'd6);
`endif

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
